nios_system_sysid_checker: RTL
==============================

NIOS_SYSTEM_SYSID_CHECKER -- requirements
Module: nios_system_sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h0000_0000: system ID value the checker requires.
REQ-002 SHALL have parameter EXPECTED_TIMESTAMP, default 32'h0000_0000: build timestamp value the checker requires.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, range 1..255: maximum number of consecutive waitrequest-high cycles allowed per read.
REQ-004 SHALL have parameter AUTO_START, default 1: when 1, a check starts automatically after reset.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: level request to run a check.
REQ-008 SHALL have port avm_address, output, 1 bit: 0 selects the ID word, 1 selects the timestamp word.
REQ-009 SHALL have port avm_read, output, 1 bit: Avalon-MM read strobe.
REQ-010 SHALL have port avm_readdata, input, 32 bits: slave read data.
REQ-011 SHALL have port avm_waitrequest, input, 1 bit: slave stall.
REQ-012 SHALL have port id_value, output, 32 bits: captured ID word.
REQ-013 SHALL have port timestamp_value, output, 32 bits: captured timestamp word.
REQ-014 SHALL have port done, output, 1 bit: the check has finished.
REQ-015 SHALL have port match, output, 1 bit: both captured words equal their expected values.
REQ-016 SHALL have port timeout_err, output, 1 bit: a read was aborted on timeout.

Function
REQ-017 SHALL implement a state machine with states IDLE, RD_ID, RD_TS and DONE.
REQ-018 SHALL transition IDLE->RD_ID when start=1 or an auto-start is pending; otherwise remain in IDLE.
REQ-019 SHALL, in RD_ID, drive avm_read=1 and avm_address=0; in RD_TS, drive avm_read=1 and avm_address=1; in all other states, drive avm_read=0 and avm_address=0.
REQ-020 SHALL treat a read as complete in the cycle where avm_read=1 and avm_waitrequest=0, with zero read latency: avm_readdata is captured in that same cycle.
REQ-021 SHALL, on read completion, capture data into id_value and go to RD_TS (RD_ID), or capture into timestamp_value and go to DONE (RD_TS).
REQ-022 SHALL hold avm_address and avm_read stable while avm_waitrequest=1.
REQ-023 SHALL use an 8-bit wait counter that clears on entry to each read state and increments on each waitrequest-high cycle.
REQ-024 SHALL, when the wait counter reaches TIMEOUT_CYCLES with waitrequest still high, set timeout_err=1 and match=0, leave the uncaptured value(s) at 0, and go to DONE.
REQ-025 SHALL, on entering DONE without timeout, set match=1 if and only if id_value==EXPECTED_ID and timestamp_value==EXPECTED_TIMESTAMP; the comparison uses the newly captured words.
REQ-026 SHALL hold done=1 in DONE and done=0 in all other states.
REQ-027 SHALL keep match and timeout_err valid only while done=1 and at 0 otherwise.
REQ-028 SHALL, when start=1 in DONE, go to RD_ID and clear done, match, timeout_err, id_value and timestamp_value.
REQ-029 SHALL ignore start while in RD_ID or RD_TS.
REQ-030 SHALL, with a zero-wait slave, perform the start sample in IDLE on cycle N, ID read on N+1, timestamp read on N+2, and assert done on N+3.
REQ-031 SHALL make the auto-start pending for exactly one pass after reset when AUTO_START=1.

Reset
REQ-032 SHALL, on reset=1 at any clock edge including mid-read, go to IDLE and set avm_read=0, avm_address=0, id_value=0, timestamp_value=0, done=0, match=0, timeout_err=0, and wait counter=0.
REQ-033 SHALL set the auto-start pending flag to AUTO_START on reset, and clear it on leaving IDLE.

Verification
REQ-034 SHALL cover: EXPECTED_ID=0, EXPECTED_TIMESTAMP=32'h5574_DAF8, zero-wait slave returning 0 and 5574_DAF8 -> done=1 three cycles after leaving reset, match=1, timeout_err=0.
REQ-035 SHALL cover: same setup but slave timestamp 32'h5574_DAF9 -> done=1, match=0, timestamp_value=5574_DAF9.
REQ-036 SHALL cover: waitrequest high 5 cycles on each read, TIMEOUT_CYCLES=16 -> done on cycle 13, address held stable, match=1.
REQ-037 SHALL cover: waitrequest stuck high, TIMEOUT_CYCLES=4 -> timeout_err=1 and done=1 after 4 stall cycles in RD_ID, id_value=0, and no RD_TS read issued.
REQ-038 SHALL cover: reset pulse during RD_TS stall -> next cycle avm_read=0 and all outputs 0; with AUTO_START=1, a fresh check completes with match=1.
REQ-039 SHALL cover: AUTO_START=0, start pulse in DONE after a pass -> outputs clear, a second pass runs, and the start pulse during RD_ID is ignored.

Source files
------------

// File: rtl/nios_system_sysid_checker.sv
// Reads the system ID and build timestamp words over Avalon-MM and compares them against
// the values this build expects; reports done/match/timeout_err.
module nios_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES     = 16,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        done,
  output logic        match,
  output logic        timeout_err
);

  typedef enum logic [1:0] {StIdle, StRdId, StRdTs, StDone} state_e;

  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  wait_cnt_inc;
  logic        auto_pend_q, auto_pend_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        done_q, done_d;
  logic        match_q, match_d;
  logic        terr_q, terr_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;

  assign wait_cnt_inc = wait_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    auto_pend_d = auto_pend_q;
    id_d        = id_q;
    ts_d        = ts_q;
    match_d     = match_q;
    terr_d      = terr_q;

    unique case (state_q)
      StIdle: begin
        if (start || auto_pend_q) begin
          state_d     = StRdId;
          auto_pend_d = 1'b0;
          wait_cnt_d  = 8'd0;
          id_d        = 32'd0;
          ts_d        = 32'd0;
          match_d     = 1'b0;
          terr_d      = 1'b0;
        end
      end
      StRdId: begin
        if (!avm_waitrequest) begin
          id_d       = avm_readdata;
          state_d    = StRdTs;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_inc;
          if (wait_cnt_inc == TimeoutLim) begin
            state_d = StDone;
            terr_d  = 1'b1;
            match_d = 1'b0;
          end
        end
      end
      StRdTs: begin
        if (!avm_waitrequest) begin
          ts_d    = avm_readdata;
          state_d = StDone;
          // Compare against the word arriving this cycle, not the stale register.
          match_d = (id_q == EXPECTED_ID) && (avm_readdata == EXPECTED_TIMESTAMP);
        end else begin
          wait_cnt_d = wait_cnt_inc;
          if (wait_cnt_inc == TimeoutLim) begin
            state_d = StDone;
            terr_d  = 1'b1;
            match_d = 1'b0;
          end
        end
      end
      StDone: begin
        if (start) begin
          state_d    = StRdId;
          wait_cnt_d = 8'd0;
          id_d       = 32'd0;
          ts_d       = 32'd0;
          match_d    = 1'b0;
          terr_d     = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Bus strobes and done are registered copies of the next-state decode.
    read_d = (state_d == StRdId) || (state_d == StRdTs);
    addr_d = (state_d == StRdTs);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      wait_cnt_q  <= 8'd0;
      auto_pend_q <= AUTO_START;
      id_q        <= 32'd0;
      ts_q        <= 32'd0;
      done_q      <= 1'b0;
      match_q     <= 1'b0;
      terr_q      <= 1'b0;
      read_q      <= 1'b0;
      addr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      auto_pend_q <= auto_pend_d;
      id_q        <= id_d;
      ts_q        <= ts_d;
      done_q      <= done_d;
      match_q     <= match_d;
      terr_q      <= terr_d;
      read_q      <= read_d;
      addr_q      <= addr_d;
    end
  end

  assign avm_read        = read_q;
  assign avm_address     = addr_q;
  assign id_value        = id_q;
  assign timestamp_value = ts_q;
  assign done            = done_q;
  assign match           = match_q;
  assign timeout_err     = terr_q;

endmodule
